// File: rtl/uart_rx.sv
// 8N1 serial receiver: 16x oversampling with its own baud tick generator.
// Emits each good byte with a one-cycle done strobe, and a one-cycle frame-error strobe when the stop bit is low.
module uart_rx #(
  parameter int N_BITS       = 8,
  parameter int BAUD_DIVISOR = 163,
  parameter int N_BITS_DIV   = 8,
  parameter int N_OVERSAMPLE = 16,
  parameter int N_STOP_TICKS = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_rx,
  output logic [N_BITS-1:0] o_rx_data,
  output logic              o_rx_done,
  output logic              o_frame_error,
  output logic              o_busy
);

  localparam int NB_STATE = 2;
  localparam int NB_S     = $clog2(N_OVERSAMPLE);
  localparam int NB_N     = $clog2(N_BITS);

  localparam logic [N_BITS_DIV-1:0] TICK_LAST = N_BITS_DIV'(BAUD_DIVISOR - 1);
  localparam logic [NB_S-1:0]       S_MID     = NB_S'(N_OVERSAMPLE / 2 - 1);
  localparam logic [NB_S-1:0]       S_LAST    = NB_S'(N_OVERSAMPLE - 1);
  localparam logic [NB_S-1:0]       S_STOP    = NB_S'(N_STOP_TICKS - 1);
  localparam logic [NB_N-1:0]       N_LAST    = NB_N'(N_BITS - 1);

  typedef enum logic [NB_STATE-1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    rx_meta_q, rx_s_q;
  logic [N_BITS_DIV-1:0]   tick_cnt_q, tick_cnt_d;
  logic [NB_S-1:0]         s_q, s_d;
  logic [NB_N-1:0]         n_q, n_d;
  logic [N_BITS-1:0]       shift_q, shift_d;
  logic [N_BITS-1:0]       data_q, data_d;
  logic                    done_q, done_d;
  logic                    ferr_q, ferr_d;
  logic                    tick;

  // Free-running divider; the tick is shared by all states so the FSM never sees a skipped or doubled tick.
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + N_BITS_DIV'(1);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + NB_S'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            shift_d = {rx_s_q, shift_q[N_BITS-1:1]};
            s_d     = '0;
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NB_N'(1);
            end
          end else begin
            s_d = s_q + NB_S'(1);
          end
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            if (rx_s_q) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_d = s_q + NB_S'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      tick_cnt_q <= '0;
      s_q        <= '0;
      n_q        <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= i_rx;
      rx_s_q     <= rx_meta_q;
      tick_cnt_q <= tick_cnt_d;
      s_q        <= s_d;
      n_q        <= n_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign o_rx_data     = data_q;
  assign o_rx_done     = done_q;
  assign o_frame_error = ferr_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIVISOR=4 (one bit = 64 clocks).
// A negedge monitor counts strobes; each scenario task checks against hand-computed values.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_error;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int cyc          = 0;
  int done_cnt     = 0;
  int err_cnt      = 0;
  int overlap_cnt  = 0;
  int long_cnt     = 0;
  int busy_cycles  = 0;
  logic prev_done  = 1'b0;
  logic prev_err   = 1'b0;
  int done_at [64];

  uart_rx #(
    .N_BITS(8),
    .BAUD_DIVISOR(4),
    .N_BITS_DIV(8),
    .N_OVERSAMPLE(16),
    .N_STOP_TICKS(16)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_rx(rx),
    .o_rx_data(rx_data),
    .o_rx_done(rx_done),
    .o_frame_error(frame_error),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      if (done_cnt < 64) done_at[done_cnt] <= cyc;
      done_cnt <= done_cnt + 1;
    end
    if (frame_error) err_cnt <= err_cnt + 1;
    if (rx_done && frame_error) overlap_cnt <= overlap_cnt + 1;
    if ((rx_done && prev_done) || (frame_error && prev_err)) long_cnt <= long_cnt + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
    prev_done <= rx_done;
    prev_err  <= frame_error;
  end

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v, input int clocks);
    rx = v;
    wait_clks(clocks);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) send_bit(b[i], BIT_CLKS);
    send_bit(stop_val, stop_len);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (rx_data !== 8'h00 || rx_done !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: data=%h done=%b ferr=%b busy=%b, required 00/0/0/0",
               rx_data, rx_done, frame_error, busy);
    end
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2 * BIT_CLKS);
    checks++;
    if (busy !== 1'b0 || done_cnt !== 0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b done_cnt=%0d err_cnt=%0d, required 0/0/0",
               busy, done_cnt, err_cnt);
    end
    $display("reset: data=%h busy=%b", rx_data, busy);
  endtask

  task automatic test_basic();
    logic [7:0] vec [2];
    int d0, e0;
    vec[0] = 8'h55;
    vec[1] = 8'hA3;
    for (int k = 0; k < 2; k++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(vec[k], 1'b1, BIT_CLKS);
      checks++;
      if (done_cnt - d0 !== 1) begin
        failures++;
        $display("FAIL basic_done_count[%0d]: got %0d pulses, required 1", k, done_cnt - d0);
      end
      checks++;
      if (rx_data !== vec[k]) begin
        failures++;
        $display("FAIL basic_data[%0d]: got %h, required %h", k, rx_data, vec[k]);
      end
      checks++;
      if (err_cnt - e0 !== 0) begin
        failures++;
        $display("FAIL basic_no_ferr[%0d]: got %0d error pulses, required 0", k, err_cnt - e0);
      end
      $display("frame sent=%h received=%h", vec[k], rx_data);
    end
    checks++;
    if (long_cnt !== 0) begin
      failures++;
      $display("FAIL basic_pulse_width: %0d multi-cycle strobes, required 0", long_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int d0, gap;
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      send_frame(8'hFF, 1'b1, BIT_CLKS);
      checks++;
      if (rx_data !== 8'hFF) begin
        failures++;
        $display("FAIL b2b_data[%0d]: got %h, required ff", k, rx_data);
      end
      $display("b2b frame %0d received=%h", k, rx_data);
    end
    checks++;
    if (done_cnt - d0 !== 4) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d pulses, required 4", done_cnt - d0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        gap = done_at[d0 + k + 1] - done_at[d0 + k];
        checks++;
        if (gap < 638 || gap > 642) begin
          failures++;
          $display("FAIL b2b_spacing[%0d]: got %0d clocks, required 640+-2", k, gap);
        end
      end
    end
  endtask

  task automatic test_frame_error();
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    // Stop bit is held low past its midpoint, then released so the line is high again
    // before the receiver would re-sample a start bit.
    send_frame(8'h3C, 1'b0, 40);
    wait_clks(2 * BIT_CLKS);
    checks++;
    if (err_cnt - e0 !== 1) begin
      failures++;
      $display("FAIL ferr_count: got %0d error pulses, required 1", err_cnt - e0);
    end
    checks++;
    if (done_cnt - d0 !== 0) begin
      failures++;
      $display("FAIL ferr_no_done: got %0d done pulses, required 0", done_cnt - d0);
    end
    checks++;
    if (rx_data !== 8'hFF) begin
      failures++;
      $display("FAIL ferr_data_held: got %h, required ff", rx_data);
    end
    $display("bad-stop frame 3c: errors=%0d data=%h", err_cnt - e0, rx_data);
    d0 = done_cnt;
    send_frame(8'h01, 1'b1, BIT_CLKS);
    checks++;
    if (done_cnt - d0 !== 1 || rx_data !== 8'h01) begin
      failures++;
      $display("FAIL ferr_recover: done pulses=%0d data=%h, required 1/01", done_cnt - d0, rx_data);
    end
    $display("frame sent=01 received=%h", rx_data);
  endtask

  task automatic test_glitch();
    int d0, e0, b0, bdelta;
    d0 = done_cnt;
    e0 = err_cnt;
    b0 = busy_cycles;
    send_bit(1'b0, 20);
    send_bit(1'b1, 2 * BIT_CLKS);
    bdelta = busy_cycles - b0;
    checks++;
    if (bdelta < 1 || bdelta >= 40) begin
      failures++;
      $display("FAIL glitch_busy: busy for %0d clocks, required 1..39", bdelta);
    end
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_no_strobe: done=%0d err=%0d busy=%b, required 0/0/0",
               done_cnt - d0, err_cnt - e0, busy);
    end
    $display("glitch: busy clocks=%0d", bdelta);
  endtask

  task automatic test_async_reset();
    logic [7:0] b;
    int d0, e0;
    b  = 8'h96;
    d0 = done_cnt;
    e0 = err_cnt;
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) send_bit(b[i], BIT_CLKS);
    send_bit(b[4], BIT_CLKS / 2);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL areset_busy_before: got %b, required 1", busy);
    end
    #2;
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    checks++;
    if (rx_data !== 8'h00 || rx_done !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL areset_outputs: data=%h done=%b ferr=%b busy=%b, required 00/0/0/0",
               rx_data, rx_done, frame_error, busy);
    end
    wait_clks(5);
    #2;
    rst = 1'b0;
    wait_clks(2 * BIT_CLKS);
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL areset_no_strobe: done=%0d err=%0d, required 0/0", done_cnt - d0, err_cnt - e0);
    end
    send_frame(b, 1'b1, BIT_CLKS);
    checks++;
    if (done_cnt - d0 !== 1 || rx_data !== 8'h96) begin
      failures++;
      $display("FAIL areset_recover: done pulses=%0d data=%h, required 1/96", done_cnt - d0, rx_data);
    end
    $display("frame sent=96 after reset received=%h", rx_data);
  endtask

  task automatic test_break();
    int d0, e0, waited;
    d0 = done_cnt;
    e0 = err_cnt;
    send_bit(1'b0, 30 * BIT_CLKS);
    checks++;
    if (err_cnt - e0 !== 3) begin
      failures++;
      $display("FAIL break_errors: got %0d error pulses, required 3", err_cnt - e0);
    end
    checks++;
    if (done_cnt - d0 !== 0) begin
      failures++;
      $display("FAIL break_no_done: got %0d done pulses, required 0", done_cnt - d0);
    end
    $display("break: errors=%0d dones=%0d", err_cnt - e0, done_cnt - d0);
    // The frame restarted by the break's tail completes on the now-high line; let it drain.
    rx = 1'b1;
    waited = 0;
    while (busy === 1'b1 && waited < 2000) begin
      wait_clks(1);
      waited++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL break_idle_timeout: busy=%b after %0d clocks, required 0", busy, waited);
    end
    wait_clks(2 * BIT_CLKS);
    d0 = done_cnt;
    send_frame(8'h7E, 1'b1, BIT_CLKS);
    checks++;
    if (done_cnt - d0 !== 1 || rx_data !== 8'h7E) begin
      failures++;
      $display("FAIL break_recover: done pulses=%0d data=%h, required 1/7e", done_cnt - d0, rx_data);
    end
    $display("frame sent=7e after break received=%h", rx_data);
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (overlap_cnt !== 0) begin
      failures++;
      $display("FAIL strobe_overlap: %0d cycles with both strobes, required 0", overlap_cnt);
    end
    checks++;
    if (long_cnt !== 0) begin
      failures++;
      $display("FAIL strobe_width: %0d multi-cycle strobes, required 0", long_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_async_reset();
    test_break();
    test_strobe_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
